// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM of the multicycle core. Decodes op/funct3/funct7b5 held in
//   the instruction register and sequences the shared ALU, memory and register
//   file through FETCH/DECODE/execute/writeback steps.
//
// Ports
//   clk        in   clock, all state changes on rising edge
//   reset      in   synchronous active-high reset
//   op         in   instr[6:0]
//   funct3     in   instr[14:12]
//   funct7b5   in   instr[30]
//   zero       in   ALU zero flag (same cycle, used by beq)
//   pcwrite    out  PC enable = pcupdate | (branch & zero)
//   adrsrc     out  memory address select: 0=PC, 1=Result
//   memwrite   out  data memory write enable
//   irwrite    out  instruction register + OldPC enable
//   resultsrc  out  00=ALUOut, 01=memory data, 10=ALU result
//   alusrca    out  00=PC, 01=OldPC, 10=rd1
//   alusrcb    out  00=rd2, 01=ImmExt, 10=constant 4
//   regwrite   out  register file write enable
//   alucontrol out  000 add, 001 sub, 010 and, 011 or, 100 xor
//   immsrc     out  00=I, 01=S, 10=B, 11=J (decoded from op in every state)
//   illegal    out  one-cycle pulse on an unsupported instruction
//   state_o    out  current state encoding, debug only
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  output logic               pcwrite,
  output logic               adrsrc,
  output logic               memwrite,
  output logic               irwrite,
  output logic [1:0]         resultsrc,
  output logic [1:0]         alusrca,
  output logic [1:0]         alusrcb,
  output logic               regwrite,
  output logic [2:0]         alucontrol,
  output logic [1:0]         immsrc,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECUTER = STATE_W'(6),
    EXECUTEI = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    JAL      = STATE_W'(9),
    BEQ      = STATE_W'(10)
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  state_t     r_state;
  state_t     w_next_state;
  logic       w_pcupdate;
  logic       w_branch;
  logic       w_adrsrc;
  logic       w_memwrite;
  logic       w_irwrite;
  logic [1:0] w_resultsrc;
  logic [1:0] w_alusrca;
  logic [1:0] w_alusrcb;
  logic       w_regwrite;
  logic [2:0] w_alucontrol;
  logic       w_illegal;

  // NOTE: state is a flop, so it is written with <= only; mixing blocking
  // assignments here would create simulation/synthesis ordering races.
  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    w_next_state = FETCH;
    w_pcupdate   = 1'b0;
    w_branch     = 1'b0;
    w_adrsrc     = 1'b0;
    w_memwrite   = 1'b0;
    w_irwrite    = 1'b0;
    w_resultsrc  = 2'b00;
    w_alusrca    = 2'b00;
    w_alusrcb    = 2'b00;
    w_regwrite   = 1'b0;
    w_alucontrol = ALU_ADD;
    w_illegal    = 1'b0;

    case (r_state)
      FETCH: begin
        w_irwrite    = 1'b1;
        w_alusrcb    = 2'b10;
        w_resultsrc  = 2'b10;
        w_pcupdate   = 1'b1;
        w_next_state = DECODE;
      end
      DECODE: begin
        // Branch target PC+imm lands in ALUOut for a possible BEQ.
        w_alusrca = 2'b01;
        w_alusrcb = 2'b01;
        case (op)
          OP_LW, OP_SW: w_next_state = MEMADR;
          OP_R:         w_next_state = EXECUTER;
          OP_I:         w_next_state = EXECUTEI;
          OP_JAL:       w_next_state = JAL;
          OP_BEQ:       w_next_state = BEQ;
          default: begin
            w_illegal    = 1'b1;
            w_next_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        w_alusrca    = 2'b10;
        w_alusrcb    = 2'b01;
        w_next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        w_adrsrc     = 1'b1;
        w_next_state = MEMWB;
      end
      MEMWB: begin
        w_resultsrc  = 2'b01;
        w_regwrite   = 1'b1;
        w_next_state = FETCH;
      end
      MEMWRITE: begin
        w_adrsrc     = 1'b1;
        w_memwrite   = 1'b1;
        w_next_state = FETCH;
      end
      EXECUTER, EXECUTEI: begin
        w_alusrca    = 2'b10;
        w_alusrcb    = (r_state == EXECUTEI) ? 2'b01 : 2'b00;
        w_next_state = ALUWB;
        case (funct3)
          // funct7b5 selects sub only for register-register ops; addi has an
          // immediate in bit 30 and must stay an add.
          3'b000:  w_alucontrol = (r_state == EXECUTER && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b100:  w_alucontrol = ALU_XOR;
          3'b110:  w_alucontrol = ALU_OR;
          3'b111:  w_alucontrol = ALU_AND;
          default: begin
            w_illegal    = 1'b1;
            w_next_state = FETCH;
          end
        endcase
      end
      ALUWB: begin
        w_regwrite   = 1'b1;
        w_next_state = FETCH;
      end
      JAL: begin
        // OldPC+4 becomes the link value; ALUOut (target) drives the PC.
        w_alusrca    = 2'b01;
        w_alusrcb    = 2'b10;
        w_pcupdate   = 1'b1;
        w_next_state = ALUWB;
      end
      BEQ: begin
        w_alusrca    = 2'b10;
        w_alucontrol = ALU_SUB;
        w_branch     = 1'b1;
        w_next_state = FETCH;
      end
      default: w_next_state = FETCH;
    endcase
  end

  // Reset masks the datapath controls combinationally so nothing is written
  // while the FSM is being forced back to FETCH.
  assign pcwrite    = ~reset & (w_pcupdate | (w_branch & zero));
  assign adrsrc     = ~reset & w_adrsrc;
  assign memwrite   = ~reset & w_memwrite;
  assign irwrite    = ~reset & w_irwrite;
  assign resultsrc  = reset ? 2'b00 : w_resultsrc;
  assign alusrca    = reset ? 2'b00 : w_alusrca;
  assign alusrcb    = reset ? 2'b00 : w_alusrcb;
  assign regwrite   = ~reset & w_regwrite;
  assign alucontrol = reset ? 3'b000 : w_alucontrol;
  assign illegal    = ~reset & w_illegal;
  assign state_o    = r_state;

  always_comb begin
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle core; sits directly upstream of the ALU and drives its 3-bit alucontrol plus all datapath mux selects and write enables.
Decodes op/funct3/funct7b5 from the instruction register and consumes the ALU zero flag for beq.
Supported instructions: lw, sw, R-type add/sub/and/or/xor, I-type addi/andi/ori/xori, jal, beq.

Parameters:
STATE_W, 4, width of state register and state_o debug port; must be >=4.

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  synchronous, active-high reset
op  in  7  instr[6:0], stable from DECODE onward
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag, same-cycle
pcwrite  out  1  PC register enable
adrsrc  out  1  memory address: 0=PC, 1=Result
memwrite  out  1  data memory write enable
irwrite  out  1  instruction register + OldPC enable
resultsrc  out  2  00=ALUOut, 01=memory data, 10=ALU result
alusrca  out  2  00=PC, 01=OldPC, 10=rd1
alusrcb  out  2  00=rd2, 01=ImmExt, 10=constant 4
regwrite  out  1  register file write enable
alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor
immsrc  out  2  00=I, 01=S, 10=B, 11=J
illegal  out  1  single-cycle pulse on unsupported instruction
state_o  out  STATE_W  current state, debug only

Behaviour:
- Reset:
  - reset high at a rising edge -> state=FETCH, from any state including mid-instruction.
  - While reset is high, all outputs except immsrc and state_o are forced to 0 combinationally.
  - First cycle after reset deasserts is FETCH.
- States (encoding = value on state_o). Listed outputs are asserted; all unlisted enables are 0, all unlisted selects are 00.
  - FETCH(0): irwrite=1, alusrcb=10, add, resultsrc=10, pcupdate=1 -> DECODE.
  - DECODE(1): alusrca=01, alusrcb=01, add (branch target into ALUOut). Next state by op:
    - 0000011/0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - other -> FETCH with illegal=1 this cycle.
  - MEMADR(2): alusrca=10, alusrcb=01, add -> MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD(3): adrsrc=1, resultsrc=00 -> MEMWB.
  - MEMWB(4): resultsrc=01, regwrite=1 -> FETCH.
  - MEMWRITE(5): adrsrc=1, resultsrc=00, memwrite=1 -> FETCH.
  - EXECUTER(6): alusrca=10, alusrcb=00, funct decode -> ALUWB.
  - EXECUTEI(7): alusrca=10, alusrcb=01, funct decode -> ALUWB.
  - ALUWB(8): resultsrc=00, regwrite=1 -> FETCH.
  - JAL(9): alusrca=01, alusrcb=10, add, resultsrc=00, pcupdate=1 -> ALUWB.
  - BEQ(10): alusrca=10, alusrcb=00, sub, resultsrc=00, branch=1 -> FETCH.
  - Encodings 11..(2^STATE_W-1): unreachable; if entered, all outputs 0, -> FETCH next cycle.
- pcwrite = pcupdate | (branch & zero); combinational, so zero->pcwrite is a same-cycle path.
- Funct decode (EXECUTER/EXECUTEI only):
  - funct3 000: sub iff state=EXECUTER and funct7b5=1, else add. funct7b5 is ignored for I-type.
  - 100 -> xor; 110 -> or; 111 -> and.
  - 001/010/011/101: alucontrol=000, illegal=1, next state FETCH (no ALUWB, no regwrite).
- immsrc: combinational from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, other 00.
- Cycles per instruction (FETCH to next FETCH): lw 5, sw 4, R/I 4, jal 4, beq 3, illegal opcode 2, illegal funct3 3.
- Never assert memwrite and regwrite in the same cycle. Assert irwrite only in FETCH.

Test Plan:
- Reset held 3 cycles in BEQ, then released -> state_o=0, all enables 0 during reset; next cycle irwrite=1, alusrcb=10, pcwrite=1.
- lw (op=0000011) -> states 0,1,2,3,4,0; MEMWB has regwrite=1, resultsrc=01; memwrite=0 throughout.
- R-type sub (funct3=000, funct7b5=1) -> EXECUTER alucontrol=001. addi with funct7b5=1 -> EXECUTEI alucontrol=000.
- R-type or/and/xor (funct3 110/111/100) -> alucontrol 011/010/100, then ALUWB regwrite=1.
- beq with zero=1 -> BEQ cycle alucontrol=001, pcwrite=1. Same with zero=0 -> pcwrite=0. Both return to FETCH.
- op=1110011 -> DECODE illegal=1, then FETCH. R-type funct3=001 -> EXECUTER illegal=1, no regwrite, then FETCH.
